// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at acceptance, held pending, and committed after a fixed latency.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxLat = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       pend_hi_q, pend_hi_d;
  logic [31:0]       pend_lo_q, pend_lo_d;
  logic              pend_we_q, pend_we_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              done_q, done_d;

  // Multiply: both forms share a 64x64 product of extended operands.
  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divide: one unsigned divider on magnitudes, signs restored afterwards for div.
  logic        is_sdiv;
  logic [31:0] a_mag, b_mag, div_n, div_d, uq, ur, quo, rem;
  assign is_sdiv = (op == OpDiv);
  assign a_mag   = a[31] ? (~a + 32'd1) : a;
  assign b_mag   = b[31] ? (~b + 32'd1) : b;
  assign div_n   = is_sdiv ? a_mag : a;
  // Zero divisor is replaced so the divider never sees it; the result is discarded anyway.
  assign div_d   = (b == 32'd0) ? 32'd1 : (is_sdiv ? b_mag : b);
  assign uq      = div_n / div_d;
  assign ur      = div_n % div_d;
  assign quo     = (is_sdiv && (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
  assign rem     = (is_sdiv && a[31]) ? (~ur + 32'd1) : ur;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu: begin
              {pend_hi_d, pend_lo_d} = (op == OpMult) ? prod_s : prod_u;
              pend_we_d = 1'b1;
              cnt_d     = CntW'(MULT_CYCLES);
              state_d   = StBusy;
            end
            OpDiv, OpDivu: begin
              pend_hi_d = rem;
              pend_lo_d = quo;
              pend_we_d = (b != 32'd0);
              cnt_d     = CntW'(DIV_CYCLES);
              state_d   = StBusy;
            end
            OpMthi:  hi_d = a;
            OpMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end
      StBusy: begin
        if (cnt_q == CntW'(1)) begin
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == StBusy);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO updates, a negedge monitor checks them.
module tb_mdu;

  localparam int unsigned MultLat = 5;
  localparam int unsigned DivLat  = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  mdu #(
    .MULT_CYCLES(MultLat),
    .DIV_CYCLES (DivLat)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  // One expected architectural event, applied by the monitor at negedge number 'due'.
  typedef struct {
    logic        rst;
    logic        we_hi;
    logic        we_lo;
    logic        pulse;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned ncyc     = 0;  // negedges seen so far
  int unsigned busy_end = 0;  // busy expected at negedges k < busy_end
  int          nchecks  = 0;
  int          nerrors  = 0;
  bit          end_req  = 1'b0;
  bit          armed    = 1'b0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;
  logic        exp_done;
  exp_t        mon_e;

  // Reference arithmetic on wide integers; returns {hi, lo}.
  function automatic logic [63:0] ref_result(input int o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint          sx, sy, p, q, r;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      1: begin
        p = sx * sy;
        return 64'(p);
      end
      2: return ux * uy;
      3: begin
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: return {x % y, x / y};
    endcase
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nerrors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, ncyc, act, req);
    end
  endfunction

  // Drive one cycle starting just after a posedge; model the accepting edge.
  task automatic step(input logic r, input logic s, input logic [2:0] o,
                      input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] res;
    int unsigned n0, lat;
    bit          mbusy;
    reset = r;
    start = s;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    n0    = ncyc;
    mbusy = (n0 < busy_end);
    e     = '{rst: 1'b0, we_hi: 1'b0, we_lo: 1'b0, pulse: 1'b0, hi: '0, lo: '0, due: n0 + 1};
    if (r) begin
      e.rst = 1'b1;
      sb.push_back(e);
      busy_end = 0;
    end else if (s && !mbusy) begin
      case (o)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          lat = (o <= 3'd2) ? MultLat : DivLat;
          if (o <= 3'd2 || y != 32'd0) begin
            res     = ref_result(int'(o), x, y);
            e.we_hi = 1'b1;
            e.we_lo = 1'b1;
            e.hi    = res[63:32];
            e.lo    = res[31:0];
          end
          e.pulse  = 1'b1;
          e.due    = n0 + lat + 1;
          busy_end = n0 + lat + 1;
          sb.push_back(e);
        end
        3'd5: begin
          e.we_hi = 1'b1;
          e.hi    = x;
          sb.push_back(e);
        end
        3'd6: begin
          e.we_lo = 1'b1;
          e.lo    = x;
          sb.push_back(e);
        end
        default: ;
      endcase
    end
    #1;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  // Advance until the next accepting edge is guaranteed to see busy low.
  task automatic wait_idle();
    while (ncyc + 1 < busy_end) idle(1);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    wait_idle();
    step(1'b0, 1'b1, o, x, y);
  endtask

  // Monitor: applies due scoreboard entries and compares every cycle after the first reset.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      exp_done = 1'b0;
      if (sb.size() > 0 && sb[$].rst && sb[$].due == ncyc) begin
        sb.delete();
        exp_hi = '0;
        exp_lo = '0;
        armed  = 1'b1;
      end else if (sb.size() > 0 && sb[0].due == ncyc) begin
        mon_e = sb.pop_front();
        if (mon_e.we_hi) exp_hi = mon_e.hi;
        if (mon_e.we_lo) exp_lo = mon_e.lo;
        exp_done = mon_e.pulse;
      end
      if (armed) begin
        check("hi", hi, exp_hi);
        check("lo", lo, exp_lo);
        check("busy", {31'd0, busy}, {31'd0, (ncyc < busy_end)});
        check("done", {31'd0, done}, {31'd0, exp_done});
      end
      if (end_req) begin
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y;
    logic [2:0]  o;
    int unsigned sel;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 3'd5, 32'hFFFF_FFFF, 32'd0);
    idle(2);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'h11, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    issue(3'd3, 32'd5, 32'd0);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    issue(3'd0, 32'h5555_5555, 32'h1);
    issue(3'd7, 32'h5555_5555, 32'h1);
    issue(3'd1, 32'd3, 32'd4);
    idle(1);
    step(1'b0, 1'b1, 3'd6, 32'h1234, 32'd0);
    issue(3'd4, 32'd9, 32'd0);
    issue(3'd1, 32'd7, 32'd6);
    idle(2);
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    idle(12);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 99);
      o   = 3'($urandom_range(0, 7));
      x   = $urandom;
      y   = $urandom;
      if (sel < 10) y = 32'd0;
      if (sel >= 10 && sel < 15) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end
      if (sel < 3) begin
        step(1'b1, 1'b1, o, x, y);
      end else if (sel >= 85) begin
        step(1'b0, 1'b1, o, x, y);
      end else begin
        issue(o, x, y);
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    wait_idle();
    idle(3);
    end_req = 1'b1;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. Executes mult, multu, div, divu, mthi and mtlo, and owns the HI/LO registers.
- Models a multi-cycle iterative unit: the operation is captured at start, the result is held pending, and it commits to HI/LO after a fixed latency.
- Exposes busy so the RR-stage hazard logic can stall mfhi/mflo and any new MDU instruction while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles from an accepted mult/multu to HI/LO commit (must be >= 1).
- DIV_CYCLES, 10, cycles from an accepted div/divu to HI/LO commit (must be >= 1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  qualifies op for one cycle; sampled on rising edge of clk.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- a  input  32  rs operand (multiplicand/dividend/mthi/mtlo source), already forwarded by EX.
- b  input  32  rt operand (multiplier/divisor).
- busy  output  1  high while a mult/div is in flight.
- done  output  1  one-cycle pulse in the cycle after HI/LO commit.
- hi  output  32  HI register value (mfhi source).
- lo  output  32  LO register value (mflo source).

Behaviour:
- Reset:
  - On an edge with reset=1: hi=0, lo=0, busy=0, done=0, counter=0, pending results cleared.
  - Reset has priority over everything, including start.
  - Reset mid-operation aborts the operation; HI/LO are never written by the aborted op.
- Acceptance:
  - start is accepted only on an edge where reset=0 and busy=0.
  - While busy=1, start and op are ignored entirely (no error, no queuing). The pipeline must stall before this point.
  - start with op 0 or 7 is a no-op.
- mult/multu/div/divu:
  - On acceptance, the 64-bit result is computed from a and b and latched into pending_hi/pending_lo.
  - counter loads LAT (MULT_CYCLES or DIV_CYCLES) and busy goes high.
  - Each following edge: if counter==1, hi<=pending_hi, lo<=pending_lo, busy<=0, done<=1, counter<=0; otherwise counter decrements.
  - Net timing: accepted at edge t -> busy=1 during cycles t+1..t+LAT -> new HI/LO visible after edge t+LAT. done is high for the single cycle after edge t+LAT.
- mthi/mtlo:
  - Single-cycle: hi<=a (mthi) or lo<=a (mtlo) on the accepting edge.
  - busy stays 0 and done is not pulsed; the other register is unchanged.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = upper 32 bits, lo = lower 32 bits.
  - multu: the same operation, unsigned.
  - div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - div overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned; lo = quotient, hi = remainder.
  - Divide by zero (b==0, div or divu): operation runs full DIV_CYCLES with busy high, but HI/LO are left unchanged at commit. done still pulses.
- Outputs:
  - hi and lo are registers driven directly, with no combinational bypass of pending results.
  - done is low in every cycle except the one after a mult/div commit.
- Back-to-back operations: a new start is legal on the same edge at which busy falls? No. busy is still 1 on that edge, so the start is ignored. The earliest accepted start is the edge after busy is observed low.

Test Plan:
- Reset, then mult a=0xFFFFFFFE (-2), b=3 -> busy high for exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then divu with the same operands -> lo=0x7FFFFFFC, hi=1.
- With hi=0x11, lo=0x22, start div a=5, b=0 -> busy for 10 cycles, done pulses, hi=0x11 and lo=0x22 unchanged. Then div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0xDEADBEEF -> hi=0xDEADBEEF next cycle, busy stays 0, lo unchanged. While a mult is busy, assert start with mtlo a=0x1234 -> ignored, lo only changes at mult commit.
- Start mult, assert reset in the 3rd busy cycle -> next cycle busy=0, hi=lo=0, done=0, and no later commit occurs.
